ifu: RTL and testbench
======================

# ifu

Parametrised multi-cycle instruction fetch unit, the next-generation front end of the RV32 core. It replaces the combinational PC register plus instruction ROM with a sequential fetch engine. The engine talks to instruction memory through a valid/ready request port and a response port, and buffers fetched instructions in a small FIFO. It presents them, with their PCs, to decode through a valid/ready handshake, and accepts redirects (branch/jump targets) from execute.

## Interface
- XLEN, 32, width of PC, addresses and instruction word.
- RESET_PC, 32'h80000000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥ 2.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  out  1  fetch request valid.
- req_ready  in  1  memory accepts request.
- req_addr  out  XLEN  fetch address, word aligned.
- resp_valid  in  1  response data valid; never back-pressured.
- resp_data  in  XLEN  fetched instruction.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decode consumes head.
- inst  out  XLEN  instruction at FIFO head.
- inst_pc  out  XLEN  PC of instruction at FIFO head.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored and forced to 0.

## Operation
- Registers:
  - fetch_pc
  - FSM state (ISSUE, WAIT)
  - drop flag
  - FIFO storage (data + pc) with rd/wr pointers and a count of width log2(FIFO_DEPTH)+1
- Credit:
  - credit = (count + (state==WAIT)) < FIFO_DEPTH.
  - Guarantees every response has a free slot.
- ISSUE:
  - req_valid = credit; req_addr = fetch_pc.
  - Once req_valid is asserted, it and req_addr stay stable until req_ready. This holds through a redirect.
  - On req_valid && req_ready: go to WAIT, latch req_addr as pending pc, fetch_pc += 4 (mod 2^XLEN).
- WAIT:
  - req_valid = 0.
  - On resp_valid: if drop = 0, push {resp_data, pending pc}; clear drop; go to ISSUE.
  - resp_valid in ISSUE is a protocol error and is ignored.
- Pop: inst_valid && inst_ready removes the head.
- Redirect (redirect_valid = 1 in a cycle):
  - FIFO flushed (count = 0, pointers reset); a pop in the same cycle is still considered consumed.
  - fetch_pc = redirect_pc & ~3.
  - If a request is outstanding (WAIT, or accepted in this same cycle), drop = 1.
  - If in ISSUE with req_valid high but not yet accepted, that request still completes and is dropped. fetch_pc after it is the redirect target, not req_addr + 4.
  - A response arriving in the same cycle as a redirect is dropped and not pushed.
  - Redirect has priority over push.
- Push and pop in the same cycle: count unchanged; allowed when full (pop frees the slot first).
- Reset (asynchronous, any time, including mid-request):
  - state = ISSUE, fetch_pc = RESET_PC, drop = 0, FIFO empty.
  - Memory must discard any in-flight transaction.
- Reset values: req_valid 0 while rst low; req_addr RESET_PC; inst_valid 0; inst/inst_pc 0.

## Timing
- First request: req_valid = 1 in the first cycle after rst deasserts, with req_addr = RESET_PC.
- req_valid is combinational from state and count; no combinational path from req_ready to req_valid.
- Response to decode: response pushed at edge N gives inst_valid = 1 from cycle N+1. Both inst and inst_pc are registered FIFO outputs.
- Throughput:
  - One instruction per 2 cycles with zero-latency memory (one accept cycle, one response cycle).
  - Next request can issue in the cycle after the response edge.
- Redirect:
  - Takes effect at the edge where sampled; inst_valid = 0 the next cycle.
  - New request issues the next cycle unless a dropped response is still pending.
- Back-pressure: with inst_ready = 0, at most FIFO_DEPTH responses are accepted, then req_valid stays 0 until a pop.

## Test plan
- Reset release, req_ready = 1, 1-cycle response latency:
  - req_addr sequence 0x80000000, 0x80000004, 0x80000008.
  - inst_pc matches each, inst = resp_data, one instruction every 2 cycles.
- inst_ready = 0, FIFO_DEPTH = 2:
  - exactly 2 requests issued, then req_valid = 0.
  - Raising inst_ready pops 0x80000000 first, and a new request for 0x80000008 issues the cycle after the first pop.
- redirect_pc = 0x80001002 while in WAIT:
  - pending response discarded, FIFO empty.
  - next req_addr = 0x80001000; next inst_pc = 0x80001000.
- redirect_valid and resp_valid in the same cycle: no push, inst_valid stays 0, next request to the redirect target.
- RESET_PC = 32'hFFFFFFFC:
  - second request address 0x00000000 (wrap).
  - req_ready held 0 for 5 cycles: req_valid and req_addr stable throughout.
- rst asserted while in WAIT with 1 FIFO entry:
  - immediately inst_valid = 0, req_valid = 0.
  - After release, fetch restarts at RESET_PC and the stale response is never delivered.

Source files
------------

// File: rtl/ifu.sv
// Sequential instruction fetch engine: one outstanding memory request,
// credit-gated issue, small instruction FIFO towards decode.
module ifu #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(32'h8000_0000),
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    ISSUE,
    WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic [XLEN-1:0] tgt_pc_q, tgt_pc_d;
  logic            drop_q, drop_d;
  logic            hold_q, hold_d;

  logic [XLEN-1:0] data_q [FIFO_DEPTH];
  logic [XLEN-1:0] data_d [FIFO_DEPTH];
  logic [XLEN-1:0] pc_q   [FIFO_DEPTH];
  logic [XLEN-1:0] pc_d   [FIFO_DEPTH];
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [CW:0]     occ;
  logic            credit;
  logic            accept;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redir_pc;

  // An outstanding request already owns a slot.
  assign occ    = {1'b0, cnt_q} + {{CW{1'b0}}, state_q == WAIT};
  assign credit = occ < (CW + 1)'(FIFO_DEPTH);

  assign req_valid  = rst && (state_q == ISSUE) && credit;
  assign req_addr   = fetch_pc_q;
  assign accept     = req_valid && req_ready;
  assign inst_valid = cnt_q != '0;
  assign inst       = data_q[rd_q];
  assign inst_pc    = pc_q[rd_q];
  assign pop        = inst_valid && inst_ready;
  assign push       = (state_q == WAIT) && resp_valid &&
                      !drop_q && !redirect_valid;
  assign redir_pc   = {redirect_pc[XLEN-1:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    tgt_pc_d   = tgt_pc_q;
    drop_d     = drop_q;
    hold_d     = hold_q;
    case (state_q)
      ISSUE: begin
        if (accept) begin
          state_d    = WAIT;
          pend_pc_d  = fetch_pc_q;
          fetch_pc_d = hold_q ? tgt_pc_q
                              : fetch_pc_q + XLEN'(4);
          drop_d     = hold_q;
          hold_d     = 1'b0;
        end
      end
      WAIT: begin
        if (resp_valid) begin
          state_d = ISSUE;
          drop_d  = 1'b0;
        end
      end
      default: state_d = ISSUE;
    endcase
    if (redirect_valid) begin
      // A presented but unaccepted request must keep its address.
      if (req_valid && !req_ready) begin
        hold_d   = 1'b1;
        tgt_pc_d = redir_pc;
      end else begin
        hold_d     = 1'b0;
        fetch_pc_d = redir_pc;
      end
      if (accept || (state_q == WAIT && !resp_valid)) begin
        drop_d = 1'b1;
      end
    end
  end

  always_comb begin
    data_d = data_q;
    pc_d   = pc_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    if (redirect_valid) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        data_d[wr_q] = resp_data;
        pc_d[wr_q]   = pend_pc_q;
        wr_d         = wr_q + AW'(1);
      end
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ISSUE;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      tgt_pc_q   <= '0;
      drop_q     <= 1'b0;
      hold_q     <= 1'b0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      tgt_pc_q   <= tgt_pc_d;
      drop_q     <= drop_d;
      hold_q     <= hold_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      pc_q       <= pc_d;
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: memory responder, pc model and
// instruction scoreboard driven from one initial block.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        w_req_valid, w_req_ready;
  logic [31:0] w_req_addr;
  logic        w_resp_valid;
  logic [31:0] w_resp_data;
  logic        w_inst_valid, w_inst_ready;
  logic [31:0] w_inst, w_inst_pc;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;

  always #5 clk = ~clk;

  ifu #(
    .XLEN(32),
    .RESET_PC(32'h8000_0000),
    .FIFO_DEPTH(2)
  ) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  ifu #(
    .XLEN(32),
    .RESET_PC(32'hFFFF_FFFC),
    .FIFO_DEPTH(2)
  ) u_wrap (
    .clk(clk), .rst(rst),
    .req_valid(w_req_valid), .req_ready(w_req_ready),
    .req_addr(w_req_addr),
    .resp_valid(w_resp_valid), .resp_data(w_resp_data),
    .inst_valid(w_inst_valid), .inst_ready(w_inst_ready),
    .inst(w_inst), .inst_pc(w_inst_pc),
    .redirect_valid(w_redirect_valid),
    .redirect_pc(w_redirect_pc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q_inst[$];
  logic [31:0] q_pc[$];
  logic [31:0] acc[$];
  int          pop_cyc[$];
  int          pops;
  int          cyc;
  bit          mem_auto;
  bit          outst;
  bit          tb_drop;
  bit          hold;
  logic [31:0] out_addr;
  logic [31:0] out_pc;
  logic [31:0] exp_fetch;
  logic [31:0] hold_tgt;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [31:0] tgt;
    if (mem_auto) begin
      resp_valid = outst;
      resp_data  = outst ? mdata(out_addr) : 32'h0;
    end
    #1;
    if (inst_valid && inst_ready) begin
      if (q_pc.size() == 0) begin
        chk("sb_extra_valid", {31'b0, inst_valid}, 32'd0);
      end else begin
        chk("pop_inst", inst, q_inst.pop_front());
        chk("pop_pc", inst_pc, q_pc.pop_front());
      end
      pops++;
      pop_cyc.push_back(cyc);
    end
    if (resp_valid && outst) begin
      if (!redirect_valid && !tb_drop) begin
        q_inst.push_back(resp_data);
        q_pc.push_back(out_pc);
      end
      tb_drop = 1'b0;
      outst   = 1'b0;
    end
    if (req_valid && req_ready) begin
      chk("req_addr", req_addr, exp_fetch);
      acc.push_back(req_addr);
      outst     = 1'b1;
      out_addr  = req_addr;
      out_pc    = exp_fetch;
      exp_fetch = hold ? hold_tgt : exp_fetch + 32'd4;
      hold      = 1'b0;
    end
    if (redirect_valid) begin
      q_inst.delete();
      q_pc.delete();
      tgt = {redirect_pc[31:2], 2'b00};
      if ((outst && !resp_valid) || req_valid) tb_drop = 1'b1;
      if (req_valid && !req_ready) begin
        hold     = 1'b1;
        hold_tgt = tgt;
      end else begin
        hold      = 1'b0;
        exp_fetch = tgt;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    resp_valid     = 1'b0;
    resp_data      = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    q_inst.delete();
    q_pc.delete();
    acc.delete();
    pop_cyc.delete();
    pops      = 0;
    cyc       = 0;
    outst     = 1'b0;
    tb_drop   = 1'b0;
    hold      = 1'b0;
    exp_fetch = 32'h8000_0000;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain();
    int k;
    req_ready = 1'b0;
    mem_auto  = 1'b1;
    k = 0;
    while ((q_pc.size() != 0 || outst) && k < 20) begin
      tick();
      k++;
    end
    chk("drain_left", q_pc.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    resp_data        = 32'h0;
    inst_ready       = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = 32'h0;
    w_req_ready      = 1'b0;
    w_resp_valid     = 1'b0;
    w_resp_data      = 32'h0;
    w_inst_ready     = 1'b0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = 32'h0;
    mem_auto         = 1'b0;

    // reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_req_addr", req_addr, 32'h8000_0000);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_w_req_addr", w_req_addr, 32'hFFFF_FFFC);
    rst = 1'b1;
    #1;
    chk("first_req_valid", {31'b0, req_valid}, 32'd1);
    chk("first_req_addr", req_addr, 32'h8000_0000);

    // streaming, zero-latency memory
    do_reset();
    inst_ready = 1'b1;
    req_ready  = 1'b1;
    mem_auto   = 1'b1;
    repeat (7) tick();
    chk("seq_a0", acc[0], 32'h8000_0000);
    chk("seq_a1", acc[1], 32'h8000_0004);
    chk("seq_a2", acc[2], 32'h8000_0008);
    chk("seq_pops", pops, 32'd3);
    chk("seq_gap1", pop_cyc[1] - pop_cyc[0], 32'd2);
    chk("seq_gap2", pop_cyc[2] - pop_cyc[1], 32'd2);
    drain();

    // back-pressure
    do_reset();
    inst_ready = 1'b0;
    req_ready  = 1'b1;
    mem_auto   = 1'b1;
    repeat (6) tick();
    chk("bp_reqs", acc.size(), 32'd2);
    chk("bp_req_valid", {31'b0, req_valid}, 32'd0);
    chk("bp_head_pc", inst_pc, 32'h8000_0000);
    inst_ready = 1'b1;
    tick();
    chk("bp_resume_valid", {31'b0, req_valid}, 32'd1);
    chk("bp_resume_addr", req_addr, 32'h8000_0008);
    drain();

    // redirect while waiting for a response
    do_reset();
    inst_ready = 1'b1;
    req_ready  = 1'b1;
    mem_auto   = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_1002;
    tick();
    redirect_valid = 1'b0;
    chk("rw_req_valid", {31'b0, req_valid}, 32'd0);
    chk("rw_inst_valid", {31'b0, inst_valid}, 32'd0);
    resp_valid = 1'b1;
    resp_data  = 32'hDEAD_BEEF;
    tick();
    resp_valid = 1'b0;
    chk("rw_no_push", {31'b0, inst_valid}, 32'd0);
    chk("rw_req_valid2", {31'b0, req_valid}, 32'd1);
    chk("rw_req_addr", req_addr, 32'h8000_1000);
    mem_auto = 1'b1;
    for (int k = 0; k < 10 && pops == 0; k++) tick();
    chk("rw_pops", pops, 32'd1);
    drain();

    // redirect in the same cycle as a response
    do_reset();
    inst_ready = 1'b1;
    req_ready  = 1'b1;
    mem_auto   = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_2000;
    tick();
    redirect_valid = 1'b0;
    chk("rr_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rr_req_valid", {31'b0, req_valid}, 32'd1);
    chk("rr_req_addr", req_addr, 32'h8000_2000);
    repeat (4) tick();
    drain();

    // redirect while a request is presented but not accepted
    do_reset();
    inst_ready = 1'b1;
    req_ready  = 1'b0;
    mem_auto   = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_3001;
    tick();
    redirect_valid = 1'b0;
    chk("hold_valid", {31'b0, req_valid}, 32'd1);
    chk("hold_addr", req_addr, 32'h8000_0000);
    req_ready = 1'b1;
    tick();
    tick();
    chk("hold_no_push", {31'b0, inst_valid}, 32'd0);
    chk("hold_next_addr", req_addr, 32'h8000_3000);
    repeat (4) tick();
    drain();

    // reset while waiting with one buffered entry
    do_reset();
    inst_ready = 1'b0;
    req_ready  = 1'b1;
    mem_auto   = 1'b1;
    repeat (3) tick();
    chk("mid_count", {31'b0, inst_valid}, 32'd1);
    mem_auto   = 1'b0;
    resp_valid = 1'b0;
    rst        = 1'b0;
    #1;
    chk("mid_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("mid_req_valid", {31'b0, req_valid}, 32'd0);
    do_reset();
    #1;
    chk("mid_restart_valid", {31'b0, req_valid}, 32'd1);
    chk("mid_restart_addr", req_addr, 32'h8000_0000);
    inst_ready = 1'b1;
    mem_auto   = 1'b1;
    repeat (6) tick();
    chk("mid_pops", pops, 32'd2);
    drain();

    // wrap-around and stall stability on the second instance
    do_reset();
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("wrap_stall_valid", {31'b0, w_req_valid}, 32'd1);
      chk("wrap_stall_addr", w_req_addr, 32'hFFFF_FFFC);
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    w_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b1;
    w_resp_data  = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    w_resp_valid = 1'b0;
    #1;
    chk("wrap_req_valid", {31'b0, w_req_valid}, 32'd1);
    chk("wrap_req_addr", w_req_addr, 32'h0000_0000);
    chk("wrap_inst_valid", {31'b0, w_inst_valid}, 32'd1);
    chk("wrap_inst_pc", w_inst_pc, 32'hFFFF_FFFC);
    chk("wrap_inst", w_inst, 32'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
